// File: rtl/stopwatch_timer.sv
// Stopwatch/timer: prescaled tick counter with run/pause/alarm control, lap capture
// and a target register compared against the count by an external comparator.
module stopwatch_timer #(
  parameter int unsigned TICK_DIV = 500000,
  parameter int unsigned WIDTH    = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             lap,
  input  logic             tgt_load,
  input  logic [WIDTH-1:0] tgt_val,
  input  logic             cmp_eq,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] lap_val,
  output logic             tick,
  output logic             alarm,
  output logic             wrap,
  output logic [1:0]       state
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] presc;
  logic          presc_done;
  logic          match;

  // Control inputs are level-sampled every cycle; a held pulse re-applies each edge.
  // cmp_eq only matters in the cycle after an increment, when tick presents the new count.
  assign presc_done = (state_q == RUN) && (presc == PRESC_LAST);
  assign match      = tick && cmp_eq && (state_q == RUN);
  assign state      = state_q;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (match) begin
      state_d = ALARM;
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (start) begin
      if (state_q != RUN) state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc   <= '0;
      count   <= '0;
      target  <= '0;
      lap_val <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state_q <= state_d;
      alarm   <= (state_d == ALARM);
      tick    <= 1'b0;
      wrap    <= 1'b0;

      // Target loads are independent of clear so a coinciding load still lands.
      if (tgt_load) target <= tgt_val;

      if (clear) begin
        presc   <= '0;
        count   <= '0;
        lap_val <= '0;
      end else begin
        if (lap) lap_val <= count;

        if (presc_done) begin
          presc <= '0;
          count <= count + 1'b1;
          tick  <= 1'b1;
          wrap  <= &count;
        end else if (state_q == RUN) begin
          presc <= presc + 1'b1;
        end

        // Prescaler phase is kept across PAUSE but discarded on leaving to IDLE/ALARM.
        if (state_d == IDLE || state_d == ALARM) presc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed bench for stopwatch_timer: tick cadence, pause/resume phase, lap, clear
// priority, match-vs-stop, reset in ALARM, and count wrap on a narrow instance.
module tb_stopwatch_timer;

  localparam int TD = 4;
  localparam int W  = 19;
  localparam int SW = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic start, stop, clear, lap, tgt_load;
  logic [W-1:0] tgt_val;
  logic cmp_eq;
  logic [W-1:0] count, target, lap_val;
  logic tick, alarm, wrap;
  logic [1:0] state;

  logic sm_start;
  logic sm_zero;
  logic [SW-1:0] sm_tgt;
  logic [SW-1:0] sm_count, sm_target, sm_lap_val;
  logic sm_tick, sm_alarm, sm_wrap;
  logic [1:0] sm_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int prev_tick = 0;
  bit sb_on = 1'b0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  // External comparator for the main instance.
  assign cmp_eq  = (count == target);
  assign sm_zero = 1'b0;
  assign sm_tgt  = '0;

  stopwatch_timer #(.TICK_DIV(TD), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .tgt_load(tgt_load), .tgt_val(tgt_val), .cmp_eq(cmp_eq), .count(count),
    .target(target), .lap_val(lap_val), .tick(tick), .alarm(alarm), .wrap(wrap),
    .state(state)
  );

  stopwatch_timer #(.TICK_DIV(TD), .WIDTH(SW)) sm_dut (
    .clk(clk), .rst_n(rst_n), .start(sm_start), .stop(sm_zero), .clear(sm_zero),
    .lap(sm_zero), .tgt_load(sm_zero), .tgt_val(sm_tgt), .cmp_eq(sm_zero),
    .count(sm_count), .target(sm_target), .lap_val(sm_lap_val), .tick(sm_tick),
    .alarm(sm_alarm), .wrap(sm_wrap), .state(sm_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard side: each tick pops the next expected count and checks the spacing.
  task automatic sb_sample();
    if (sb_on && tick === 1'b1) begin
      chk("tick_gap", 32'(cyc_n - prev_tick), TD);
      prev_tick = cyc_n;
      if (exp_q.size() == 0) chk("sb_extra_tick", 32'(exp_q.size()), 1);
      else chk("tick_count", 32'(count), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    sb_sample();
  endtask

  task automatic wait_count(input string tag, input logic [W-1:0] c, input int budget);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!(tick === 1'b1 && count === c) && n < budget);
    if (!(tick === 1'b1 && count === c)) chk({tag, "_timeout"}, 32'({tick, count}), 32'({1'b1, c}));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
    tgt_load = 1'b0; tgt_val = '0; sm_start = 1'b0;

    repeat (3) cyc();
    chk("rst_state", 32'(state), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_target", 32'(target), 0);
    chk("rst_lap", 32'(lap_val), 0);
    chk("rst_flags", 32'({tick, wrap, alarm}), 0);
    rst_n = 1'b1;
    cyc();

    // Count to a target of 5, then alarm and hold.
    tgt_val = 19'd5; tgt_load = 1'b1; cyc(); tgt_load = 1'b0;
    chk("tgt_load", 32'(target), 5);
    for (int i = 1; i <= 5; i++) exp_q.push_back(W'(i));
    start = 1'b1; cyc(); start = 1'b0;
    prev_tick = cyc_n; sb_on = 1'b1;
    chk("run_state", 32'(state), 1);
    n = 0;
    while (state !== 2'd3 && n < 40) begin cyc(); n++; end
    chk("alarm_state", 32'(state), 3);
    chk("alarm_flag", 32'(alarm), 1);
    chk("alarm_count", 32'(count), 5);
    chk("sb_drain", 32'(exp_q.size()), 0);
    repeat (8) cyc();
    chk("alarm_hold", 32'(count), 5);
    chk("alarm_stay", 32'(state), 3);
    sb_on = 1'b0;

    // Clear with a coinciding target load; target 100 is never reached below.
    clear = 1'b1; tgt_val = 19'd100; tgt_load = 1'b1; cyc();
    clear = 1'b0; tgt_load = 1'b0;
    chk("clr_state", 32'(state), 0);
    chk("clr_count", 32'(count), 0);
    chk("clr_alarm", 32'(alarm), 0);
    chk("clr_load_target", 32'(target), 100);

    // Pause after two prescaler steps; resume must tick two cycles later.
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("pause_state", 32'(state), 2);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (tick === 1'b1 || count !== '0) n++;
    end
    chk("pause_hold", 32'(n), 0);
    chk("pause_state2", 32'(state), 2);
    start = 1'b1; cyc(); start = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (tick !== 1'b1 && n < 10);
    chk("resume_latency", 32'(n), 2);
    chk("resume_count", 32'(count), 1);

    // Lap sampled on the 6 -> 7 increment edge.
    wait_count("to_six", 19'd6, 40);
    repeat (3) cyc();
    lap = 1'b1; cyc(); lap = 1'b0;
    chk("lap_tick", 32'(tick), 1);
    chk("lap_count", 32'(count), 7);
    chk("lap_val", 32'(lap_val), 6);

    // start+stop+clear together at count 9: clear wins.
    wait_count("to_nine", 19'd9, 20);
    start = 1'b1; stop = 1'b1; clear = 1'b1; cyc();
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    chk("tri_state", 32'(state), 0);
    chk("tri_count", 32'(count), 0);
    chk("tri_lap", 32'(lap_val), 0);
    chk("tri_target", 32'(target), 100);

    // Match in the same cycle as stop goes to ALARM.
    tgt_val = 19'd2; tgt_load = 1'b1; cyc(); tgt_load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    wait_count("to_two", 19'd2, 20);
    chk("match_cmp", 32'(cmp_eq), 1);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("match_stop_state", 32'(state), 3);
    chk("match_stop_alarm", 32'(alarm), 1);
    chk("match_stop_count", 32'(count), 2);

    // Start from ALARM resumes from the held count.
    exp_q.push_back(W'(3));
    exp_q.push_back(W'(4));
    start = 1'b1; cyc(); start = 1'b0;
    prev_tick = cyc_n; sb_on = 1'b1;
    chk("alarm_resume_state", 32'(state), 1);
    tgt_val = 19'd4; tgt_load = 1'b1; cyc(); tgt_load = 1'b0;
    n = 0;
    while (state !== 2'd3 && n < 20) begin cyc(); n++; end
    chk("resume_alarm_state", 32'(state), 3);
    chk("resume_alarm_count", 32'(count), 4);
    chk("sb_drain2", 32'(exp_q.size()), 0);
    sb_on = 1'b0;

    // Lap in ALARM, then a one-cycle reset.
    lap = 1'b1; cyc(); lap = 1'b0;
    chk("alarm_lap", 32'(lap_val), 4);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("rst2_state", 32'(state), 0);
    chk("rst2_count", 32'(count), 0);
    chk("rst2_target", 32'(target), 0);
    chk("rst2_lap", 32'(lap_val), 0);
    chk("rst2_flags", 32'({tick, wrap, alarm}), 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (tick === 1'b1 || count !== '0 || state !== 2'd0) n++;
    end
    chk("rst2_quiet", 32'(n), 0);

    // Wrap on the narrow instance: 63 -> 0 with a single wrap pulse.
    sm_start = 1'b1; cyc(); sm_start = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (!(sm_tick === 1'b1 && sm_count === 6'd63) && n < 300);
    chk("wrap_reach", 32'({sm_tick, sm_count}), 32'h7F);
    chk("wrap_early", 32'(sm_wrap), 0);
    n = 0;
    do begin cyc(); n++; end while (sm_tick !== 1'b1 && n < 10);
    chk("wrap_gap", 32'(n), TD);
    chk("wrap_count", 32'(sm_count), 0);
    chk("wrap_pulse", 32'(sm_wrap), 1);
    cyc();
    chk("wrap_one_cycle", 32'({sm_wrap, sm_tick}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_timer.md
STOPWATCH_TIMER -- requirements
Module: stopwatch_timer

Interface
REQ-001 Parameter TICK_DIV, default 500000, clk cycles per count tick (100 Hz from 50 MHz); legal range 2..2^20.
REQ-002 Parameter WIDTH, default 19, width of the count and target words.
REQ-003 The block SHALL have one clock, clk, and a synchronous active-low reset, rst_n.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse; begin or resume counting.
REQ-007 stop  input  1  one-cycle pulse; pause counting.
REQ-008 clear  input  1  one-cycle pulse; zero the count and return to IDLE.
REQ-009 lap  input  1  one-cycle pulse; capture the current count into lap_val.
REQ-010 tgt_load  input  1  one-cycle pulse; load tgt_val into the target register.
REQ-011 tgt_val  input  WIDTH  new target value.
REQ-012 cmp_eq  input  1  equality result from the external comparator (count == target), combinational from count/target.
REQ-013 count  output  WIDTH  running time count in ticks; drives comparator operand A.
REQ-014 target  output  WIDTH  target register; drives comparator operand B.
REQ-015 lap_val  output  WIDTH  last captured lap count.
REQ-016 tick  output  1  one-cycle pulse on each count increment.
REQ-017 alarm  output  1  high while in ALARM.
REQ-018 wrap  output  1  one-cycle pulse when count wraps from 2^WIDTH-1 to 0.
REQ-019 state  output  2  IDLE=0, RUN=1, PAUSE=2, ALARM=3.

Function
REQ-020 Prescaler SHALL count 0..TICK_DIV-1 only in RUN, and SHALL hold its value in PAUSE and be zero in IDLE/ALARM.
REQ-021 When the prescaler is at TICK_DIV-1 in RUN it SHALL return to 0, count SHALL increment by 1, and tick SHALL pulse in the following cycle together with the new count.
REQ-022 Count SHALL wrap modulo 2^WIDTH; on the 2^WIDTH-1 -> 0 increment wrap SHALL pulse in the same cycle as tick.
REQ-023 Match check: in the cycle tick is high, if cmp_eq is high and state is RUN, the next state SHALL be ALARM (one-cycle check latency after the increment); cmp_eq is ignored in all other cycles.
REQ-024 Transitions: IDLE-start->RUN; RUN-stop->PAUSE; PAUSE-start->RUN; any state-clear->IDLE; ALARM-start->RUN (counting resumes from the held count); all other pulses leave state unchanged.
REQ-025 Priority when pulses coincide: clear > stop > start; a match (REQ-023) in the same cycle as stop SHALL take ALARM.
REQ-026 Clear SHALL zero count, prescaler and lap_val, and drop alarm, in the next cycle; target SHALL be unaffected.
REQ-027 Lap SHALL capture count as it is at the sampling edge (pre-increment value if coinciding with a tick), in any state.
REQ-028 tgt_load SHALL update target the next cycle in any state; a load coinciding with clear SHALL still take effect.
REQ-029 Count SHALL hold in IDLE, PAUSE and ALARM; alarm SHALL be 1 exactly when state == ALARM.
REQ-030 Pulses held high for several cycles SHALL be treated as level: start/stop/clear re-evaluated every cycle, lap re-captured every cycle.

Reset
REQ-031 rst_n low at a clk edge SHALL set state=IDLE, count=0, target=0, lap_val=0, prescaler=0, tick=0, wrap=0, alarm=0, overriding every other input.
REQ-032 Reset asserted mid-RUN or in ALARM SHALL take effect on the next edge with no partial tick emitted.

Verification (TICK_DIV=4, WIDTH=19)
REQ-033 Reset, tgt_load 5, start -> tick every 4 cycles, count 1..5; after count=5 alarm=1, state=3, count holds 5.
REQ-034 RUN, stop after 2 prescaler cycles, wait 20, start -> next tick exactly 2 cycles after resume; count unchanged during pause.
REQ-035 Force count to 524287 via run with target 0 unreachable (cmp_eq stubbed 0) -> next tick gives count=0 with wrap=1 for one cycle.
REQ-036 start, stop and clear in the same cycle while RUN with count=9 -> state=IDLE, count=0, lap_val=0, target kept.
REQ-037 lap on a tick edge at count 6->7 -> lap_val=6; rst_n low for one cycle in ALARM -> all outputs zero, state=IDLE next cycle.
